ggm_tree_sequencer: RTL

- Next-generation control sequencer for the GGM tree expansion and hash datapath of the OT accelerator.
- Issues parent-node reads to the node buffer and, after a fixed AES pipeline latency, writes back child nodes (expand) or hashed leaf messages (hash).
- Generalised over tree depth, AES pipeline latency and number of parallel AES lanes.
- Adds a start/done handshake, AES back-pressure and a per-level drain barrier.

---
 rtl/ggm_tree_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ggm_tree_sequencer.sv
// GGM tree expansion / hash sequencer: issues parent-node reads, retires write-backs after AES_LATENCY.
// Optional busy-cycle counter is built only when GGM_PERF_CNT_EN is defined.
module ggm_tree_sequencer #(
    parameter int D           = 3,
    parameter int LANES       = 1,
    parameter int AES_LATENCY = 29,
    localparam int ADDR_W     = D + 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic                    i_func,
    input  logic                    i_aes_ready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [7:0]              o_level,
    output logic                    o_rd_en,
    output logic [LANES-1:0]        o_rd_mask,
    output logic [LANES*ADDR_W-1:0] o_rd_addr,
    output logic [LANES-1:0]        o_rd_offset,
    output logic                    o_wr_en,
    output logic [LANES-1:0]        o_wr_mask,
    output logic [LANES*ADDR_W-1:0] o_wr_addr,
    output logic                    o_msg_wr_en,
    output logic [LANES*ADDR_W-1:0] o_msg_w_addr,
    output logic [31:0]             o_cycle_count
);

    // state | meaning: IDLE reset | PRNG seed beat | EXPAND levels 1..D | HASH leaf pass | DONE finished
    typedef enum logic [2:0] {S_IDLE, S_PRNG, S_EXPAND, S_HASH, S_DONE} state_t;

    localparam int                     LAST     = AES_LATENCY - 1;
    localparam logic [AES_LATENCY-1:0] DL_EARLY = {AES_LATENCY{1'b1}} >> 1;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_func;
    logic [7:0]              r_level;
    logic [ADDR_W-1:0]       r_j;
    logic [ADDR_W-1:0]       w_width;
    logic                    w_active;
    logic                    w_issue;
    logic                    w_pass_end;
    logic                    w_start_acc;
    logic [LANES-1:0]        w_mask;
    logic [LANES*ADDR_W-1:0] w_idx;
    logic [AES_LATENCY-1:0]  r_dl_vld;
    logic [LANES-1:0]        r_dl_mask [AES_LATENCY];
    logic [LANES*ADDR_W-1:0] r_dl_idx  [AES_LATENCY];

    always_comb begin
        w_width = '0;
        case (r_state)
            S_PRNG:   w_width = ADDR_W'(1);
            S_EXPAND: w_width = ADDR_W'(1) << r_level;
            S_HASH:   w_width = ADDR_W'(1) << D;
            default:  w_width = '0;
        endcase
    end

    assign w_active    = (r_state == S_PRNG) || (r_state == S_EXPAND) || (r_state == S_HASH);
    assign w_issue     = w_active && i_aes_ready && (r_j < w_width);
    assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Pass ends on its final write: everything issued and only the oldest stage still occupied.
    assign w_pass_end  = w_active && (r_j >= w_width) && r_dl_vld[LAST] &&
                         ((r_dl_vld & DL_EARLY) == '0);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ADDR_W-1:0] w_i;
        logic              w_v;
        assign w_i = r_j + ADDR_W'(k);
        assign w_v = w_issue && (w_i < w_width);
        assign w_mask[k]                       = w_v;
        assign w_idx[k*ADDR_W +: ADDR_W]       = w_v ? w_i : '0;
        assign o_rd_addr[k*ADDR_W +: ADDR_W]   = !w_v ? '0 : (r_state == S_HASH) ? w_i : (w_i >> 1);
        assign o_rd_offset[k]                  = w_v && (r_state != S_HASH) && w_i[0];
        assign o_wr_addr[k*ADDR_W +: ADDR_W]   = r_func ? '0 : r_dl_idx[LAST][k*ADDR_W +: ADDR_W];
        assign o_msg_w_addr[k*ADDR_W +: ADDR_W] = r_func ? r_dl_idx[LAST][k*ADDR_W +: ADDR_W] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start)    w_next_state = i_func ? S_HASH : S_PRNG;
            S_PRNG:         if (w_pass_end) w_next_state = S_EXPAND;
            S_EXPAND:       if (w_pass_end) w_next_state = (r_level == 8'(D)) ? S_DONE : S_EXPAND;
            S_HASH:         if (w_pass_end) w_next_state = S_DONE;
            default:        w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = w_active;
        o_done      = (r_state == S_DONE);
        o_level     = r_level;
        o_rd_en     = w_issue;
        o_rd_mask   = w_mask;
        o_wr_en     = r_dl_vld[LAST] && !r_func;
        o_msg_wr_en = r_dl_vld[LAST] && r_func;
        o_wr_mask   = r_dl_vld[LAST] ? r_dl_mask[LAST] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_func  <= 1'b0;
            r_level <= '0;
            r_j     <= '0;
        end else if (w_start_acc) begin
            r_func  <= i_func;
            r_level <= '0;
            r_j     <= '0;
        end else if (w_pass_end) begin
            r_j <= '0;
            if ((r_state == S_PRNG) || ((r_state == S_EXPAND) && (r_level != 8'(D)))) begin
                r_level <= r_level + 8'd1;
            end
        end else if (w_issue) begin
            r_j <= r_j + ADDR_W'(LANES);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dl_vld <= '0;
            for (int i = 0; i < AES_LATENCY; i++) begin
                r_dl_mask[i] <= '0;
                r_dl_idx[i]  <= '0;
            end
        end else begin
            r_dl_vld[0]  <= w_issue;
            r_dl_mask[0] <= w_mask;
            r_dl_idx[0]  <= w_idx;
            for (int i = 1; i < AES_LATENCY; i++) begin
                r_dl_vld[i]  <= r_dl_vld[i-1];
                r_dl_mask[i] <= r_dl_mask[i-1];
                r_dl_idx[i]  <= r_dl_idx[i-1];
            end
        end
    end

`ifdef GGM_PERF_CNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_count <= '0;
        end else if (w_start_acc) begin
            r_cycle_count <= '0;
        end else if (w_active && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = '0;
`endif

endmodule
